// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit and its neighbours.
// Holds the FSM state type, funct3 load encodings, access size encodings,
// the canonical NOP instruction, and small lane/alignment helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_READ  = 2'd1,
    LSU_WRITE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] DATA_TYPE_LB  = 3'd0;
  localparam logic [2:0] DATA_TYPE_LH  = 3'd1;
  localparam logic [2:0] DATA_TYPE_LW  = 3'd2;
  localparam logic [2:0] DATA_TYPE_LBU = 3'd4;
  localparam logic [2:0] DATA_TYPE_LHU = 3'd5;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Fed to the controller when a fetch times out, so it decodes harmlessly.
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  // Any size with bit 1 set is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    if (size[1])              return offset != 2'b00;
    else if (size == SIZE_HALF) return offset[0];
    else                      return 1'b0;
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] offset);
    if (size[1])              return 4'hF;
    else if (size == SIZE_HALF) return 4'b0011 << offset;
    else                      return 4'b0001 << offset;
  endfunction

  // Replicating the datum across lanes lets the slave pick it up from
  // whichever lanes are enabled, with no shifter on this side.
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
    if (size[1])              return data;
    else if (size == SIZE_HALF) return {2{data[15:0]}};
    else                      return {4{data[7:0]}};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Ready-handshaked memory bus between the load/store unit and a slave.
// master: address/write_data/byte_enable/read/write out, ready/read_data in.
// slave: the mirror image.
interface load_store_unit_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        read;
  logic        write;
  logic        ready;
  logic [31:0] read_data;

  modport master (
    output address, write_data, byte_enable, read, write,
    input  ready, read_data
  );

  modport slave (
    input  address, write_data, byte_enable, read, write,
    output ready, read_data
  );
endinterface

// File: rtl/load_store_unit_load_extender.sv
// Picks the addressed lane out of the buffered load word and extends it.
// Ports: buffer (word as read), offset (byte address bits), data_type (funct3)
// in; result out. Purely combinational.
module load_extender
  import load_store_unit_pkg::*;
(
  input  logic [31:0] buffer,
  input  logic [1:0]  offset,
  input  logic [2:0]  data_type,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = buffer[{offset, 3'b000} +: 8];
    // Halves are always aligned, so only offset[1] selects.
    half_lane = offset[1] ? buffer[31:16] : buffer[15:0];
    case (data_type)
      DATA_TYPE_LB:  result = {{24{byte_lane[7]}}, byte_lane};
      DATA_TYPE_LH:  result = {{16{half_lane[15]}}, half_lane};
      DATA_TYPE_LW:  result = buffer;
      DATA_TYPE_LBU: result = {24'h0, byte_lane};
      DATA_TYPE_LHU: result = {16'h0, half_lane};
      default:       result = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-side stage: converts pad strobes into one ready-handshaked bus
// transaction, stalls the phase generator while it is outstanding, captures
// fetch/load data, and extends buffered load data for write-back.
// Ports: clock/reset, phase, address, store_data, pad_*, input_buffer_*,
// data_type in; bus (master); fetch_data, load_result, stall, misaligned,
// bus_error out.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:1]              phase,
  input  logic [31:0]             address,
  input  logic [31:0]             store_data,
  input  logic                    pad_read,
  input  logic                    pad_write,
  input  logic [1:0]              pad_data_size,
  input  logic                    input_buffer_write,
  input  logic                    input_buffer_read,
  input  logic [2:0]              data_type,
  load_store_unit_if.master       bus,
  output logic [31:0]             fetch_data,
  output logic [31:0]             load_result,
  output logic                    stall,
  output logic                    misaligned,
  output logic                    bus_error
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state, next_state;
  logic        bad_align, accept_read, accept_write, reject, timeout, finish;

  logic [31:0] address_q, write_data_q, buffer_q, extended;
  logic [3:0]  byte_enable_q;
  logic        read_q, write_q, is_fetch_q;
  logic [1:0]  req_offset_q, buffer_offset_q;
  logic [2:0]  buffer_type_q;
  logic [15:0] wait_count;

  // Request decode: write wins when both strobes are up.
  always_comb begin
    bad_align    = is_misaligned(pad_data_size, address[1:0]);
    accept_write = (state == LSU_IDLE) && pad_write && !bad_align;
    accept_read  = (state == LSU_IDLE) && !pad_write && pad_read && !bad_align;
    reject       = (state == LSU_IDLE) && (pad_read || pad_write) && bad_align;
    // A ready on the final allowed wait cycle still completes normally.
    timeout      = (state != LSU_IDLE) && !bus.ready && (wait_count == WAIT_LAST);
    finish       = (state != LSU_IDLE) && (bus.ready || timeout);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= LSU_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LSU_IDLE: begin
        if (accept_write)     next_state = LSU_WRITE;
        else if (accept_read) next_state = LSU_READ;
      end
      LSU_READ, LSU_WRITE: begin
        if (finish) next_state = LSU_IDLE;
      end
      default: next_state = LSU_IDLE;
    endcase
  end

  // Stall covers the entry cycle too, so the controller's pad strobes and
  // phase-gated registers freeze before the bus request goes out.
  always_comb begin
    stall = accept_read || accept_write || (state != LSU_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      address_q       <= '0;
      write_data_q    <= '0;
      byte_enable_q   <= '0;
      read_q          <= 1'b0;
      write_q         <= 1'b0;
      is_fetch_q      <= 1'b0;
      req_offset_q    <= '0;
      wait_count      <= '0;
      fetch_data      <= '0;
      buffer_q        <= '0;
      buffer_offset_q <= '0;
      buffer_type_q   <= '0;
      misaligned      <= 1'b0;
      bus_error       <= 1'b0;
    end else begin
      misaligned <= reject;
      bus_error  <= timeout;
      if (accept_read || accept_write) begin
        address_q     <= {address[31:2], 2'b00};
        req_offset_q  <= address[1:0];
        byte_enable_q <= lane_enables(pad_data_size, address[1:0]);
        write_data_q  <= lane_replicate(pad_data_size, store_data);
        read_q        <= accept_read;
        write_q       <= accept_write;
        is_fetch_q    <= phase[1] && !phase[2];
        wait_count    <= '0;
      end else if (finish) begin
        read_q        <= 1'b0;
        write_q       <= 1'b0;
        byte_enable_q <= '0;
        wait_count    <= '0;
        if (state == LSU_READ) begin
          if (is_fetch_q) begin
            fetch_data <= bus.ready ? bus.read_data : NOP_INSTRUCTION;
          end else if (input_buffer_write) begin
            buffer_q        <= bus.ready ? bus.read_data : 32'h0;
            buffer_offset_q <= req_offset_q;
            buffer_type_q   <= data_type;
          end
        end
      end else if (state != LSU_IDLE) begin
        wait_count <= wait_count + 16'd1;
      end
    end
  end

  assign bus.address     = address_q;
  assign bus.write_data  = write_data_q;
  assign bus.byte_enable = byte_enable_q;
  assign bus.read        = read_q;
  assign bus.write       = write_q;

  load_extender u_load_extender (
    .buffer    (buffer_q),
    .offset    (buffer_offset_q),
    .data_type (buffer_type_q),
    .result    (extended)
  );

  assign load_result = input_buffer_read ? extended : 32'h0;

endmodule
